// File: rtl/bin_to_digits.sv
// bin_to_digits: sequential signed binary to decimal digit codes (double dabble) for 7-segment decoders
module bin_to_digits #(
   parameter int WIDTH = 16,
   parameter int NDIG  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WIDTH-1:0]  value,
   input  logic              blank_lz,
   output logic              busy,
   output logic              done,
   output logic [5*NDIG-1:0] digits,
   output logic              neg,
   output logic              ovf
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
   state_t              state_q;
   logic [WIDTH-1:0]    mag_q;
   logic [4*NDIG-1:0]   bcd_q, adj;
   logic [CW-1:0]       cnt_q;
   logic                sign_q, blz_q, ovfi_q, busy_q, done_q, neg_q, ovf_q;
   logic [5*NDIG-1:0]   digits_q, digits_d;
   logic                neg_d, lead;
   logic [3:0]          nib;
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < NDIG; i++)
         adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
   end
   // leading-zero blanking scans from the top digit down; digit 0 always shows
   always_comb begin
      lead = blz_q;
      nib = '0;
      digits_d = '0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         nib = bcd_q[4*i +: 4];
         lead = lead && nib == 4'd0 && i != 0;
         digits_d[5*i +: 5] = ovfi_q ? 5'h0F : lead ? 5'h10 : {1'b0, nib};
      end
      neg_d = sign_q && (ovfi_q || bcd_q != '0);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         mag_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         blz_q    <= 1'b0;
         ovfi_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         digits_q <= {NDIG{5'h10}};
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               mag_q   <= value[WIDTH-1] ? -value : value;
               sign_q  <= value[WIDTH-1];
               blz_q   <= blank_lz;
               bcd_q   <= '0;
               ovfi_q  <= 1'b0;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= SHIFT;
            end
            SHIFT: begin
               bcd_q   <= {adj[4*NDIG-2:0], mag_q[WIDTH-1]};
               mag_q   <= {mag_q[WIDTH-2:0], 1'b0};
               ovfi_q  <= ovfi_q | adj[4*NDIG-1];
               cnt_q   <= cnt_q + 1'b1;
               state_q <= cnt_q == CW'(WIDTH - 1) ? FORMAT : SHIFT;
            end
            FORMAT: begin
               digits_q <= digits_d;
               neg_q    <= neg_d;
               ovf_q    <= ovfi_q;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy   = busy_q;
   assign done   = done_q;
   assign digits = digits_q;
   assign neg    = neg_q;
   assign ovf    = ovf_q;
endmodule

// File: tb/tb_bin_to_digits.sv
// tb_bin_to_digits: directed tests of bin_to_digits with NDIG=5 and NDIG=3 instances
module tb_bin_to_digits;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] value = '0;
   logic        blank_lz = 1'b0;
   logic        busy5, done5, neg5, ovf5, busy3, done3, neg3, ovf3;
   logic [24:0] digits5;
   logic [14:0] digits3;
   int          n_chk = 0;
   int          n_fail = 0;
   int          lat;

   always #5 clk = ~clk;

   bin_to_digits #(.WIDTH(16), .NDIG(5)) u5 (
      .clk(clk), .reset(reset), .start(start), .value(value), .blank_lz(blank_lz),
      .busy(busy5), .done(done5), .digits(digits5), .neg(neg5), .ovf(ovf5));
   bin_to_digits #(.WIDTH(16), .NDIG(3)) u3 (
      .clk(clk), .reset(reset), .start(start), .value(value), .blank_lz(blank_lz),
      .busy(busy3), .done(done3), .digits(digits3), .neg(neg3), .ovf(ovf3));

   task automatic wait_done(output int l);
      l = 0;
      for (int k = 0; k < 40 && !done5; k++) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic run(input logic [15:0] v, input logic b, output int l);
      @(negedge clk);
      value = v; blank_lz = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(l);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if ({busy5, done5, neg5, ovf5} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {busy5, done5, neg5, ovf5}); end
      n_chk++; if (digits5 !== {5{5'h10}}) begin n_fail++; $display("FAIL reset_digits5 got %h want %h", digits5, {5{5'h10}}); end
      n_chk++; if (digits3 !== {3{5'h10}}) begin n_fail++; $display("FAIL reset_digits3 got %h want %h", digits3, {3{5'h10}}); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic;
      @(negedge clk);
      value = 16'd1234; blank_lz = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_chk++; if (busy5 !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy5); end
      wait_done(lat);
      n_chk++; if (lat != 17 || done5 !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %0d want 17", lat); end
      n_chk++; if (digits5 !== {5'h10, 5'h01, 5'h02, 5'h03, 5'h04}) begin n_fail++; $display("FAIL basic_digits got %h want %h", digits5, {5'h10, 5'h01, 5'h02, 5'h03, 5'h04}); end
      n_chk++; if ({neg5, ovf5, busy5} !== 3'b000) begin n_fail++; $display("FAIL basic_flags got %b want 000", {neg5, ovf5, busy5}); end
      @(posedge clk); #1;
      n_chk++; if (done5 !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done5); end
   endtask

   task automatic test_sign_zero;
      run(16'hFFFF, 1'b1, lat);
      n_chk++; if (digits5 !== {5'h10, 5'h10, 5'h10, 5'h10, 5'h01} || neg5 !== 1'b1) begin n_fail++; $display("FAIL minus1 got %h neg %b want %h neg 1", digits5, neg5, {5'h10, 5'h10, 5'h10, 5'h10, 5'h01}); end
      run(16'd0, 1'b1, lat);
      n_chk++; if (digits5 !== {5'h10, 5'h10, 5'h10, 5'h10, 5'h00} || neg5 !== 1'b0) begin n_fail++; $display("FAIL zero got %h neg %b want %h neg 0", digits5, neg5, {5'h10, 5'h10, 5'h10, 5'h10, 5'h00}); end
   endtask

   task automatic test_extremes;
      run(16'h8000, 1'b0, lat);
      n_chk++; if (digits5 !== {5'h03, 5'h02, 5'h07, 5'h06, 5'h08} || neg5 !== 1'b1 || ovf5 !== 1'b0) begin n_fail++; $display("FAIL min_neg got %h neg %b ovf %b want %h neg 1 ovf 0", digits5, neg5, ovf5, {5'h03, 5'h02, 5'h07, 5'h06, 5'h08}); end
      n_chk++; if (digits3 !== {3{5'h0F}} || ovf3 !== 1'b1 || neg3 !== 1'b1) begin n_fail++; $display("FAIL min_neg_n3 got %h ovf %b neg %b want %h ovf 1 neg 1", digits3, ovf3, neg3, {3{5'h0F}}); end
      run(16'd7, 1'b0, lat);
      n_chk++; if (digits5 !== {5'h00, 5'h00, 5'h00, 5'h00, 5'h07} || neg5 !== 1'b0) begin n_fail++; $display("FAIL seven_nolz got %h want %h", digits5, {5'h00, 5'h00, 5'h00, 5'h00, 5'h07}); end
   endtask

   task automatic test_overflow;
      run(16'd1000, 1'b1, lat);
      n_chk++; if (digits3 !== {3{5'h0F}} || ovf3 !== 1'b1 || neg3 !== 1'b0) begin n_fail++; $display("FAIL ovf_1000 got %h ovf %b neg %b want %h ovf 1 neg 0", digits3, ovf3, neg3, {3{5'h0F}}); end
      n_chk++; if (digits5 !== {5'h10, 5'h01, 5'h00, 5'h00, 5'h00} || ovf5 !== 1'b0) begin n_fail++; $display("FAIL n5_1000 got %h ovf %b want %h ovf 0", digits5, ovf5, {5'h10, 5'h01, 5'h00, 5'h00, 5'h00}); end
      run(16'd999, 1'b0, lat);
      n_chk++; if (digits3 !== {3{5'h09}} || ovf3 !== 1'b0) begin n_fail++; $display("FAIL n3_999 got %h ovf %b want %h ovf 0", digits3, ovf3, {3{5'h09}}); end
   endtask

   task automatic test_busy_ignore;
      int ndone;
      run(16'd4321, 1'b1, lat);
      @(negedge clk);
      value = 16'd1234; blank_lz = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      value = 16'd555; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done5) ndone++;
      end
      n_chk++; if (ndone != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
      n_chk++; if (digits5 !== {5'h10, 5'h01, 5'h02, 5'h03, 5'h04}) begin n_fail++; $display("FAIL ignore_digits got %h want %h", digits5, {5'h10, 5'h01, 5'h02, 5'h03, 5'h04}); end
   endtask

   task automatic test_back_to_back;
      run(16'd42, 1'b1, lat);
      value = 16'hFFF7; blank_lz = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_chk++; if (busy5 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept busy got %b want 1", busy5); end
      n_chk++; if (digits5 !== {5'h10, 5'h10, 5'h10, 5'h04, 5'h02}) begin n_fail++; $display("FAIL b2b_hold got %h want %h", digits5, {5'h10, 5'h10, 5'h10, 5'h04, 5'h02}); end
      wait_done(lat);
      n_chk++; if (lat != 17 || done5 !== 1'b1) begin n_fail++; $display("FAIL b2b_latency got %0d want 17", lat); end
      n_chk++; if (digits5 !== {5'h10, 5'h10, 5'h10, 5'h10, 5'h09} || neg5 !== 1'b1) begin n_fail++; $display("FAIL b2b_digits got %h neg %b want %h neg 1", digits5, neg5, {5'h10, 5'h10, 5'h10, 5'h10, 5'h09}); end
   endtask

   task automatic test_reset_abort;
      int ndone;
      @(negedge clk);
      value = 16'd1234; blank_lz = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (done5) ndone++;
      end
      n_chk++; if (ndone != 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", ndone); end
      n_chk++; if (digits5 !== {5{5'h10}} || {busy5, neg5, ovf5} !== 3'b000) begin n_fail++; $display("FAIL abort_outputs got %h flags %b want %h flags 000", digits5, {busy5, neg5, ovf5}, {5{5'h10}}); end
      run(16'd5, 1'b1, lat);
      n_chk++; if (lat != 17 || digits5 !== {5'h10, 5'h10, 5'h10, 5'h10, 5'h05}) begin n_fail++; $display("FAIL abort_restart lat %0d got %h want 17 %h", lat, digits5, {5'h10, 5'h10, 5'h10, 5'h10, 5'h05}); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_sign_zero;
      test_extremes;
      test_overflow;
      test_busy_ignore;
      test_back_to_back;
      test_reset_abort;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
